// File: rtl/sram_width_ctrl_if.sv
// Narrow-access request/response port plus the 1k x 32 macro side of sram_width_ctrl.
// slave: the controller; master: the requester and the macro model facing it.
interface sram_width_ctrl_if #(
    parameter int MEM_AW = 10
);
    logic [2:0]        cfg_conf;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [14:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic              mem_en;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  cfg_conf, req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cfg_conf, req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sram_width_ctrl.sv
// Width-configurable narrow port in front of a 1k x 32 SRAM macro.
// Narrow writes are read-modify-write since the macro has no bit mask.
//
// state | meaning
// IDLE  | ready for a request
// RD    | macro read strobe for the addressed word
// CAP   | capture read word: extract slot (read) or merge new slot (write)
// WR    | macro write strobe (full word or merged word)
// RSP   | response held until rsp_ready
module sram_width_ctrl #(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    sram_width_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RSP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  conf_q;
    logic        we_q;
    logic [14:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;

    logic              accept;
    logic              req_bad;
    logic [14:0]       req_word;
    logic [MEM_AW-1:0] word_idx;
    logic [4:0]        slot;
    logic [4:0]        offset;
    logic [5:0]        width;
    logic [31:0]       mask;

    always_comb begin
        req_word = bus.req_addr >> bus.cfg_conf;
        req_bad  = (bus.cfg_conf > 3'd5) || ((req_word >> MEM_AW) != 15'd0);
        accept   = (state_q == IDLE) && !rst && bus.req_valid;
        // Decode of the latched request; only meaningful for valid conf codes.
        word_idx = MEM_AW'(addr_q >> conf_q);
        slot     = addr_q[4:0] & ((5'd1 << conf_q) - 5'd1);
        offset   = slot << (3'd5 - conf_q);
        width    = 6'd32 >> conf_q;
        mask     = 32'hFFFF_FFFF >> (6'd32 - width);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = !rst;
                if (accept) begin
                    if (req_bad)                                   state_d = RSP;
                    else if (bus.req_we && bus.cfg_conf == 3'd0)   state_d = WR;
                    else                                           state_d = RD;
                end
            end
            RD: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = word_idx;
                state_d      = CAP;
            end
            CAP: state_d = we_q ? WR : RSP;
            WR: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = word_idx;
                bus.mem_wdata = (conf_q == 3'd0) ? wdata_q : merge_q;
                state_d       = RSP;
            end
            RSP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conf_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                conf_q     <= bus.cfg_conf;
                we_q       <= bus.req_we;
                addr_q     <= bus.req_addr;
                wdata_q    <= bus.req_wdata;
                rsp_data_q <= '0;
                rsp_err_q  <= req_bad;
            end
            if (state_q == CAP) begin
                if (we_q)
                    merge_q <= (bus.mem_rdata & ~(mask << offset)) | ((wdata_q & mask) << offset);
                else
                    rsp_data_q <= (bus.mem_rdata >> offset) & mask;
            end
            if (state_q == RSP && bus.rsp_ready) begin
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b0;
            end
        end
    end

    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_err  = rsp_err_q;
endmodule

// File: tb/tb_sram_width_ctrl.sv
// Bench for sram_width_ctrl: macro model, transaction-level reference of the logical
// memory, per-cycle output expectations, directed cases and randomized traffic.
module tb_sram_width_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sram_width_ctrl_if #(.MEM_AW(10)) bus ();
    sram_width_ctrl #(.MEM_AW(10)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Macro: synchronous 1k x 32, read data valid the cycle after the strobe.
    logic [31:0] macro_mem [1024];
    logic [31:0] rdata_r;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) macro_mem[bus.mem_addr] <= bus.mem_wdata;
            else            rdata_r <= macro_mem[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = rdata_r;

    typedef struct {
        logic        rdy, en, we;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic        vld;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] ref_mem [1024];
    int          checks = 0;
    int          errors = 0;
    int          en_cnt = 0;
    logic [31:0] last_rsp_data, last_wr_data;
    logic        last_rsp_err;
    logic [9:0]  last_rd_addr;

    function automatic exp_t mk(input logic en, input logic we, input logic [9:0] a,
                                input logic [31:0] wd, input logic vld,
                                input logic [31:0] rd, input logic err);
        exp_t e;
        e.rdy = 1'b0; e.en = en; e.we = we; e.addr = a; e.wd = wd;
        e.vld = vld; e.rd = rd; e.err = err;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) e = expq.pop_front();
        else begin
            e = mk(1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 32'd0, 1'b0);
            e.rdy = !rst;
        end
        checks++;
        if (bus.req_ready !== e.rdy || bus.mem_en !== e.en || bus.mem_we !== e.we ||
            bus.mem_addr !== e.addr || bus.mem_wdata !== e.wd || bus.rsp_valid !== e.vld ||
            bus.rsp_data !== e.rd || bus.rsp_err !== e.err) begin
            errors++;
            $display("FAIL cycle@%0t actual/required: rdy %b/%b en %b/%b we %b/%b addr %h/%h wdata %h/%h vld %b/%b data %h/%h err %b/%b",
                     $time, bus.req_ready, e.rdy, bus.mem_en, e.en, bus.mem_we, e.we,
                     bus.mem_addr, e.addr, bus.mem_wdata, e.wd, bus.rsp_valid, e.vld,
                     bus.rsp_data, e.rd, bus.rsp_err, e.err);
        end
        if (bus.rsp_valid) begin
            last_rsp_data = bus.rsp_data;
            last_rsp_err  = bus.rsp_err;
        end
        if (bus.mem_en) en_cnt++;
        if (bus.mem_en && bus.mem_we)  last_wr_data = bus.mem_wdata;
        if (bus.mem_en && !bus.mem_we) last_rd_addr = bus.mem_addr;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, req);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Logical view: W-bit items packed 32/W per word, item k at bit k*W.
    function automatic void decode(input int conf, input int addr, output int word,
                                   output int off, output logic [31:0] mask, output bit err);
        int w, per;
        word = 0; off = 0; mask = '0; err = 1'b1;
        if (conf > 5) return;
        w    = 32 >> conf;
        per  = 32 / w;
        word = addr / per;
        off  = (addr % per) * w;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'((33'd1 << w) - 33'd1);
        err  = (word >= 1024);
    endfunction

    task automatic txn(input int conf, input int addr, input bit we, input logic [31:0] wd,
                       input int stall, input bit rst_in_cap);
        int word, off, lat;
        logic [31:0] mask, oldv, newv, rdv;
        bit err;
        decode(conf, addr, word, off, mask, err);
        step();
        bus.cfg_conf  = 3'(conf);
        bus.req_addr  = 15'(addr);
        bus.req_we    = we;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'($urandom);
        rdv = '0; newv = '0;
        if (err) lat = 1;
        else begin
            oldv = ref_mem[word];
            if (!we) begin
                lat = 3;
                rdv = (oldv >> off) & mask;
                expq.push_back(mk(1'b1, 1'b0, 10'(word), 32'd0, 1'b0, 32'd0, 1'b0));
                expq.push_back(mk(1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 32'd0, 1'b0));
            end else if (conf == 0) begin
                lat = 2;
                newv = wd;
                expq.push_back(mk(1'b1, 1'b1, 10'(word), newv, 1'b0, 32'd0, 1'b0));
            end else begin
                lat = 4;
                newv = (oldv & ~(mask << off)) | ((wd & mask) << off);
                expq.push_back(mk(1'b1, 1'b0, 10'(word), 32'd0, 1'b0, 32'd0, 1'b0));
                expq.push_back(mk(1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 32'd0, 1'b0));
                if (!rst_in_cap)
                    expq.push_back(mk(1'b1, 1'b1, 10'(word), newv, 1'b0, 32'd0, 1'b0));
            end
        end
        if (!rst_in_cap) begin
            for (int i = 0; i <= stall; i++)
                expq.push_back(mk(1'b0, 1'b0, 10'd0, 32'd0, 1'b1, rdv, err));
            if (we && !err) ref_mem[word] = newv;
        end
        for (int c = 1; c <= lat + stall; c++) begin
            step();
            if (c == 1) begin
                bus.req_valid = 1'b0;
                bus.req_addr  = 15'($urandom);
                bus.req_wdata = $urandom;
                bus.req_we    = 1'($urandom);
                bus.cfg_conf  = 3'($urandom);
            end
            if (rst_in_cap && c == 2) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                return;
            end
            bus.rsp_ready = (c < lat) ? 1'($urandom) : (c == lat + stall);
        end
    endtask

    initial begin
        int n0, conf, per, word, addr;
        logic [31:0] v;
        bus.cfg_conf = '0; bus.req_valid = 1'b0; bus.req_we = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
        #1 rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            v = (i == 0) ? 32'h8000_0000 : (i == 1) ? 32'h1122_3344 :
                (i == 7) ? 32'hCAFE_F00D : $urandom;
            txn(0, i, 1'b1, v, 0, 1'b0);
        end
        chk("preload_word1", macro_mem[1], 32'h1122_3344);

        txn(2, 5, 1'b0, 32'h0, 0, 1'b0);
        chk("rd8_addr", 32'(last_rd_addr), 32'd1);
        chk("rd8_data", last_rsp_data, 32'h0000_0033);
        chk("rd8_err", 32'(last_rsp_err), 32'd0);
        txn(2, 5, 1'b1, 32'hFFFF_FFAB, 0, 1'b0);
        chk("rmw8_wdata", last_wr_data, 32'h1122_AB44);
        txn(2, 5, 1'b0, 32'h0, 1, 1'b0);
        chk("rmw8_readback", last_rsp_data, 32'h0000_00AB);

        txn(5, 31, 1'b0, 32'h0, 0, 1'b0);
        chk("rd1_bit31", last_rsp_data, 32'd1);
        txn(5, 31, 1'b1, 32'h0, 0, 1'b0);
        chk("wr1_word0", macro_mem[0], 32'h0);
        txn(5, 32, 1'b0, 32'h0, 0, 1'b0);
        chk("rd1_addr32", 32'(last_rd_addr), 32'd1);

        n0 = en_cnt;
        txn(0, 'h3FF, 1'b1, 32'hDEAD_BEEF, 0, 1'b0);
        chk("full_wr_word", macro_mem[10'h3FF], 32'hDEAD_BEEF);
        chk("full_wr_one_strobe", 32'(en_cnt - n0), 32'd1);

        n0 = en_cnt;
        txn(0, 'h400, 1'b0, 32'h0, 0, 1'b0);
        chk("err_range_err", 32'(last_rsp_err), 32'd1);
        chk("err_range_data", last_rsp_data, 32'd0);
        txn(7, 3, 1'b1, 32'h55, 2, 1'b0);
        chk("err_conf7_err", 32'(last_rsp_err), 32'd1);
        chk("err_no_strobe", 32'(en_cnt - n0), 32'd0);

        txn(2, 5, 1'b0, 32'h0, 5, 1'b0);
        chk("stall_data", last_rsp_data, 32'h0000_00AB);

        txn(2, 28, 1'b1, 32'h0000_0012, 0, 1'b1);
        chk("rst_abort_word", macro_mem[7], 32'hCAFE_F00D);
        txn(0, 7, 1'b0, 32'h0, 0, 1'b0);
        chk("rst_abort_readback", last_rsp_data, 32'hCAFE_F00D);

        for (int t = 0; t < 300; t++) begin
            conf = ($urandom_range(0, 9) < 9) ? $urandom_range(0, 5) : $urandom_range(6, 7);
            per  = (conf > 5) ? 1 : (1 << conf);
            word = $urandom_range(0, 15);
            addr = word * per + $urandom_range(0, per - 1);
            if (conf < 5 && $urandom_range(0, 9) == 0)
                addr = 1024 * per + $urandom_range(0, 32767 - 1024 * per);
            txn(conf, addr, 1'($urandom), $urandom, $urandom_range(0, 3), 1'b0);
            repeat ($urandom_range(0, 2)) begin
                step();
                bus.rsp_ready = 1'($urandom);
                bus.req_addr  = 15'($urandom);
            end
        end

        step();
        for (int i = 0; i < 16; i++)
            chk($sformatf("final_word%0d", i), macro_mem[i], ref_mem[i]);
        chk("final_word3ff", macro_mem[10'h3FF], ref_mem[10'h3FF]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
